hidden_neuron_seq: RTL and testbench
====================================

// Module: hidden_neuron_seq
// PURPOSE
//  Parametrised, sequential hidden-layer neuron for the drowsiness-detector network.
//  - Streams N_INPUTS (input, weight) pairs through one signed multiplier.
//  - Accumulates the products at full precision and adds a per-neuron bias.
//  - Applies the activation f(x) = 0.5*(x/(1+|x|)+1) using a multi-cycle restoring divider.
//  - Returns one unsigned fixed-point activation per transaction over a valid/ready output.
// PARAMETERS
//  N_INPUTS  10  pairs per transaction (>=1)
//  DATA_W    10  width of in_val/weight/bias; signed two's complement, Q(DATA_W-FRAC_W).FRAC_W
//  FRAC_W    8   fractional bits; must be < DATA_W; also the divide cycle count
//  ACC_W     2*DATA_W+$clog2(N_INPUTS)+1  accumulator width (derived; do not override)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous active-low reset
//  start      in   1       begin transaction; honoured only in IDLE
//  bias       in   DATA_W  signed bias, sampled when start is honoured
//  in_valid   in   1       in_val/weight beat valid
//  in_ready   out  1       neuron accepts a beat
//  in_val     in   DATA_W  signed input activation
//  weight     in   DATA_W  signed weight
//  out_valid  out  1       activation result valid
//  out_ready  in   1       downstream accepts result
//  out_val    out  DATA_W  activation, unsigned Q0.FRAC_W, zero-extended, range [0,1)
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge, any state, including mid-transaction):
//  - state=IDLE; accumulator, beat counter and divider cleared.
//  - in_ready=0, out_valid=0, out_val=0, busy=0. Partial results are discarded.
//  State machine: IDLE -> ACCUM -> DIVIDE -> OUTPUT -> IDLE
//  - IDLE: start=1 => acc <= bias<<<FRAC_W (sign-extended to Q.2F), cnt <= 0, go to ACCUM.
//    in_valid is ignored in IDLE.
//  - ACCUM: in_ready=1.
//    Each beat with in_valid&&in_ready: acc += sext(in_val*weight) (full 2*DATA_W-bit product, Q.2F).
//    cnt increments per beat. The beat where cnt==N_INPUTS-1 moves to DIVIDE on the next cycle.
//    Cycles with in_valid=0 are stalls; no timeout.
//  - DIVIDE: exactly FRAC_W cycles of restoring division, one quotient bit per cycle, MSB first.
//    x = acc, m = |x| (ACC_W bits; no overflow due to headroom bit).
//    Divisor D = 2^(2*FRAC_W) + m. Quotient q = floor(m*2^FRAC_W / D), so 0 <= q < 2^FRAC_W.
//  - OUTPUT: out_valid=1 and out_val held stable until out_ready=1, then go to IDLE.
//    out_val = (2^FRAC_W + q)>>1 if x>=0, else (2^FRAC_W - q)>>1 (truncating shift).
//    x==0 gives 2^(FRAC_W-1).
//  Latency: last beat accepted at posedge T => out_valid first high after posedge T+FRAC_W+1.
//  - out_ready=1 on that cycle: out_valid drops next cycle, IDLE; next start is honoured one cycle later.
//  start while busy is ignored; it is neither queued nor an error.
//  out_ready while out_valid=0 has no effect.
//  No saturation is needed anywhere; ACC_W covers the worst case N_INPUTS*(-2^(DATA_W-1))^2 + bias.
// TESTING (N_INPUTS=10, DATA_W=10, FRAC_W=8)
//  1. All in_val=0, weight=0, bias=0 -> out_val=128 (0x080), out_valid at T+9.
//  2. in_val=256, weight=256 (1.0*1.0) x10, bias=0 -> x=10.0, q=232, out_val=244.
//  3. in_val=256, weight=-256 x10, bias=0 -> q=232, out_val=12.
//  4. in_val=-512, weight=-512 x10, bias=-512 -> x=38.0, no overflow, q=249, out_val=252.
//     Then repeat case 2 with in_valid toggled 1/0 -> same 244; 10 accepted beats counted.
//  5. Hold out_ready=0 for 5 cycles -> out_val/out_valid stable.
//     start pulses during ACCUM/DIVIDE/OUTPUT are ignored (busy stays 1).
//  6. rst_n=0 after beat 5 -> next cycle all outputs 0, IDLE.
//     A fresh case-1 transaction then returns 128.

Source files
------------

// File: rtl/hidden_neuron_seq.sv
// Sequential hidden-layer neuron: multiply-accumulate over N_INPUTS beats, add a bias,
// then apply f(x) = 0.5*(x/(1+|x|)+1) with a bit-serial restoring divider.
module hidden_neuron_seq #(
    parameter int N_INPUTS = 10,
    parameter int DATA_W   = 10,
    parameter int FRAC_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_val,
    input  logic signed [DATA_W-1:0] weight,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [DATA_W-1:0] out_val,
    output logic                     busy
);

    localparam int ACC_W  = 2*DATA_W + $clog2(N_INPUTS) + 1;
    localparam int DIV_W  = ACC_W + 1;
    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int DCNT_W = $clog2(FRAC_W + 1);

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(N_INPUTS - 1);
    localparam logic [DCNT_W-1:0] LAST_DIV  = DCNT_W'(FRAC_W);
    localparam logic [DIV_W-1:0]  DIV_BASE  = DIV_W'(1) << (2*FRAC_W);
    localparam logic [FRAC_W:0]   ONE_Q     = {1'b1, {FRAC_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIVIDE,
        OUTPUT
    } stateT;

    stateT                    state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         beatCnt;
    logic [DIV_W-1:0]         rem;
    logic [DIV_W-1:0]         divisor;
    logic [FRAC_W-1:0]        quot;
    logic [DCNT_W-1:0]        divCnt;
    logic                     xNeg;

    logic signed [2*DATA_W-1:0] prodFull;
    logic signed [ACC_W-1:0]    prodExt;
    logic signed [ACC_W-1:0]    biasExt;
    logic signed [ACC_W-1:0]    accSum;
    logic [DIV_W-1:0]           remShift;
    logic [DIV_W-1:0]           remNext;
    logic                       qBit;
    logic [FRAC_W-1:0]          quotNext;

    // |x| as an unsigned divider operand; the accumulator headroom bit keeps -x representable.
    function automatic logic [DIV_W-1:0] magnitude(input logic signed [ACC_W-1:0] x);
        logic [ACC_W-1:0] m;
        m = x[ACC_W-1] ? -x : x;
        return {1'b0, m};
    endfunction

    // 0.5*(1 +/- q/2^FRAC_W), truncated, as unsigned Q0.FRAC_W zero-extended to DATA_W.
    function automatic logic [DATA_W-1:0] activate(input logic [FRAC_W-1:0] q,
                                                   input logic neg);
        logic [FRAC_W:0] sum;
        sum = neg ? (ONE_Q - {1'b0, q}) : (ONE_Q + {1'b0, q});
        return DATA_W'(sum[FRAC_W:1]);
    endfunction

    assign prodFull = in_val * weight;
    assign prodExt  = {{(ACC_W-2*DATA_W){prodFull[2*DATA_W-1]}}, prodFull};
    assign biasExt  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    assign accSum   = acc + prodExt;

    // Restoring step: remainder stays below the divisor, so the shift never overflows.
    assign remShift = {rem[DIV_W-2:0], 1'b0};
    assign qBit     = (remShift >= divisor);
    assign remNext  = qBit ? (remShift - divisor) : remShift;
    assign quotNext = FRAC_W'({quot, qBit});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            beatCnt   <= '0;
            rem       <= '0;
            divisor   <= '0;
            quot      <= '0;
            divCnt    <= '0;
            xNeg      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_val   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= biasExt <<< FRAC_W;
                        beatCnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= accSum;
                        if (beatCnt == LAST_BEAT) begin
                            in_ready <= 1'b0;
                            divCnt   <= '0;
                            state    <= DIVIDE;
                        end else begin
                            beatCnt <= beatCnt + 1'b1;
                        end
                    end
                end

                // First DIVIDE cycle loads the operands; the next FRAC_W cycles each yield one bit.
                DIVIDE: begin
                    if (divCnt == '0) begin
                        rem     <= magnitude(acc);
                        divisor <= DIV_BASE + magnitude(acc);
                        xNeg    <= acc[ACC_W-1];
                        quot    <= '0;
                        divCnt  <= divCnt + 1'b1;
                    end else begin
                        rem  <= remNext;
                        quot <= quotNext;
                        if (divCnt == LAST_DIV) begin
                            out_val   <= activate(quotNext, xNeg);
                            out_valid <= 1'b1;
                            state     <= OUTPUT;
                        end else begin
                            divCnt <= divCnt + 1'b1;
                        end
                    end
                end

                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_val   <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_neuron_seq.sv
// Self-checking bench for hidden_neuron_seq: directed transactions, an arithmetic
// reference model with cycle-exact output timing, and literal expected activations.
module tb_hidden_neuron_seq;

    localparam int N  = 10;
    localparam int DW = 10;
    localparam int FW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [DW-1:0] bias = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_val = '0;
    logic signed [DW-1:0] weight = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic        [DW-1:0] out_val;
    logic                 busy;

    hidden_neuron_seq #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .weight(weight),
        .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nCmp = 0;
    int nErr = 0;
    bit cmpEn = 1'b0;
    bit pending = 1'b0;
    int readyAt = 0;
    int pendVal = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: x is the pre-activation in units of 2^-(2*FW).
    function automatic int modelAct(input longint x);
        longint m, d, q, r;
        m = (x < 0) ? -x : x;
        d = (longint'(1) << (2*FW)) + m;
        q = (m * (longint'(1) << FW)) / d;
        r = (x >= 0) ? (((longint'(1) << FW) + q) / 2) : (((longint'(1) << FW) - q) / 2);
        return int'(r);
    endfunction

    // Every cycle: out_valid must be high exactly from the model's ready cycle until handshake.
    always @(negedge clk) begin
        bit ev;
        if (cmpEn) begin
            ev = pending && (cyc >= readyAt);
            check("out_valid", {31'd0, out_valid}, {31'd0, ev});
            if (ev) begin
                check("out_val", {22'd0, out_val}, pendVal);
                if (out_ready) pending = 1'b0;
            end
        end
    end

    task automatic runTxn(input string tag, input int b, input int iv, input int dIv,
                          input int wv, input int dWv, input bit gaps, input bit pokeStart,
                          input int hold, output int got);
        longint x;
        int accepted, guard, t0, phase;
        bit rdy;
        x = longint'(b) * (longint'(1) << FW);
        bias  = DW'(b);
        start = 1'b1;
        @(posedge clk); #1;
        start = pokeStart;
        bias  = '0;
        check({tag, " in_ready"}, {31'd0, in_ready}, 1);
        check({tag, " busy"}, {31'd0, busy}, 1);
        accepted = 0;
        guard = 0;
        phase = 0;
        while (accepted < N && guard < 200) begin
            in_val   = DW'(iv + accepted*dIv);
            weight   = DW'(wv + accepted*dWv);
            in_valid = gaps ? (phase % 2 == 0) : 1'b1;
            phase++;
            rdy = in_ready;
            @(posedge clk); #1;
            guard++;
            if (in_valid && rdy) begin
                x += longint'(in_val) * longint'(weight);
                accepted++;
            end
        end
        in_valid = 1'b0;
        t0 = cyc;
        check({tag, " beats"}, accepted, N);
        check({tag, " in_ready after last"}, {31'd0, in_ready}, 0);
        pendVal = modelAct(x);
        readyAt = t0 + FW + 1;
        pending = 1'b1;
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " latency"}, cyc - t0, FW + 1);
        got = int'(out_val);
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, " hold val"}, {22'd0, out_val}, got);
            check({tag, " hold busy"}, {31'd0, busy}, 1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " busy after"}, {31'd0, busy}, 0);
        check({tag, " valid after"}, {31'd0, out_valid}, 0);
    endtask

    initial begin
        int got;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 0);
        check("reset out_val", {22'd0, out_val}, 0);
        check("reset in_ready", {31'd0, in_ready}, 0);
        check("reset busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        cmpEn = 1'b1;

        in_valid = 1'b1;
        in_val = DW'(100);
        weight = DW'(100);
        repeat (3) begin
            @(posedge clk); #1;
            check("idle in_ready", {31'd0, in_ready}, 0);
            check("idle busy", {31'd0, busy}, 0);
        end
        in_valid = 1'b0;

        runTxn("zero", 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, got);
        check("zero literal", got, 128);
        runTxn("pos10", 0, 256, 0, 256, 0, 1'b0, 1'b0, 0, got);
        check("pos10 literal", got, 244);
        runTxn("neg10", 0, 256, 0, -256, 0, 1'b0, 1'b0, 0, got);
        check("neg10 literal", got, 12);
        runTxn("maxmag", -512, -512, 0, -512, 0, 1'b0, 1'b0, 0, got);
        check("maxmag literal", got, 252);
        runTxn("gaps", 0, 256, 0, 256, 0, 1'b1, 1'b0, 0, got);
        check("gaps literal", got, 244);
        runTxn("holdpoke", 0, 256, 0, -256, 0, 1'b0, 1'b1, 5, got);
        check("holdpoke literal", got, 12);
        runTxn("biasonly", -20, 0, 0, 0, 0, 1'b0, 1'b0, 1, got);
        check("biasonly literal", got, 119);
        runTxn("mixed", 100, -300, 67, 90, -41, 1'b1, 1'b0, 2, got);

        // Reset in the middle of accumulation.
        bias = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_val = DW'(256);
        weight = DW'(256);
        repeat (5) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset out_valid", {31'd0, out_valid}, 0);
        check("midreset out_val", {22'd0, out_val}, 0);
        check("midreset in_ready", {31'd0, in_ready}, 0);
        check("midreset busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        runTxn("afterreset", 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, got);
        check("afterreset literal", got, 128);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", nCmp);
        $fatal(1, "timeout");
    end

endmodule
